// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 user-interface arbiter.
package ddr3_arb_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrCmd  = 3'd1,
    StRdCmd  = 3'd2,
    StWrData = 3'd3,
    StRdData = 3'd4
  } arb_state_e;

  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } req_sel_e;

  localparam logic [2:0] DDR3_CMD_WR = 3'b000;
  localparam logic [2:0] DDR3_CMD_RD = 3'b001;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin: on a tie, the side not served last wins.
module rr_arb2
  import ddr3_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_req_wr,
  input  logic     i_req_rd,
  input  logic     i_upd,
  input  req_sel_e i_upd_sel,
  output logic     o_valid,
  output req_sel_e o_sel
);

  req_sel_e r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_RD;
    end else if (i_upd) begin
      r_last <= i_upd_sel;
    end
  end

  always_comb begin
    o_valid = i_req_wr | i_req_rd;
    o_sel   = REQ_WR;
    if (i_req_wr && i_req_rd) begin
      if (r_last == REQ_WR) begin
        o_sel = REQ_RD;
      end
    end else if (i_req_rd) begin
      o_sel = REQ_RD;
    end
  end

endmodule

// File: rtl/jpeg_ddr3_arbiter.sv
// Shares the DDR3 user interface between the MJPEG writer and the UDP reader,
// one burst at a time, with a watchdog that abandons stalled data phases.
module jpeg_ddr3_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned BURST_BEATS = 8,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned ADDR_W      = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [127:0]      w_data,
  output logic              w_gnt,
  output logic              w_data_req,
  output logic              w_done,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_gnt,
  output logic [127:0]      r_data,
  output logic              r_valid,
  output logic              r_done,
  output logic              err,
  input  logic              cmd_ready,
  output logic [2:0]        cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic              wr_data_rdy,
  output logic [127:0]      wr_data,
  output logic              wr_data_en,
  output logic              wr_data_end,
  output logic [15:0]       wr_data_mask,
  input  logic [127:0]      rd_data,
  input  logic              rd_data_valid,
  input  logic              rd_data_end
);

  localparam int unsigned CntW  = $clog2(BURST_BEATS + 1);
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0]  LastBeat = CntW'(BURST_BEATS - 1);
  localparam logic [WdogW-1:0] WdogMax  = WdogW'(TIMEOUT);

  arb_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_lat_addr, w_lat_addr_nxt;
  logic [CntW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [WdogW-1:0]  r_wdog, w_wdog_nxt;

  logic     w_arb_valid;
  req_sel_e w_arb_sel;
  logic     w_arb_upd;
  req_sel_e w_side;
  logic     w_beat;

  // The beat count is authoritative; the IP's end-of-burst flag is not needed.
  logic w_unused_rd_end;
  assign w_unused_rd_end = rd_data_end;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_wr  (w_req),
    .i_req_rd  (r_req),
    .i_upd     (w_arb_upd),
    .i_upd_sel (w_side),
    .o_valid   (w_arb_valid),
    .o_sel     (w_arb_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_lat_addr <= '0;
      r_beat_cnt <= '0;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat_addr <= w_lat_addr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_wdog     <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lat_addr_nxt = r_lat_addr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_wdog_nxt     = r_wdog;
    w_arb_upd      = 1'b0;
    w_side         = REQ_WR;
    w_beat         = 1'b0;
    w_gnt          = 1'b0;
    w_data_req     = 1'b0;
    w_done         = 1'b0;
    r_gnt          = 1'b0;
    r_data         = '0;
    r_valid        = 1'b0;
    r_done         = 1'b0;
    err            = 1'b0;
    cmd            = DDR3_CMD_WR;
    cmd_en         = 1'b0;
    addr           = '0;
    wr_data        = '0;
    wr_data_en     = 1'b0;
    wr_data_end    = 1'b0;
    wr_data_mask   = '0;

    unique case (r_state)
      StIdle: begin
        if (init_calib_complete && w_arb_valid) begin
          if (w_arb_sel == REQ_WR) begin
            w_lat_addr_nxt = w_addr;
            w_state_nxt    = StWrCmd;
          end else begin
            w_lat_addr_nxt = r_addr;
            w_state_nxt    = StRdCmd;
          end
        end
      end
      StWrCmd: begin
        cmd_en = 1'b1;
        cmd    = DDR3_CMD_WR;
        addr   = r_lat_addr;
        if (cmd_ready) begin
          w_gnt          = 1'b1;
          w_beat_cnt_nxt = '0;
          w_wdog_nxt     = '0;
          w_state_nxt    = StWrData;
        end
      end
      StRdCmd: begin
        cmd_en = 1'b1;
        cmd    = DDR3_CMD_RD;
        addr   = r_lat_addr;
        if (cmd_ready) begin
          r_gnt          = 1'b1;
          w_beat_cnt_nxt = '0;
          w_wdog_nxt     = '0;
          w_state_nxt    = StRdData;
        end
      end
      StWrData: begin
        w_side      = REQ_WR;
        w_beat      = wr_data_rdy;
        wr_data_en  = wr_data_rdy;
        wr_data_end = wr_data_rdy;
        w_data_req  = wr_data_rdy;
        wr_data     = w_data;
      end
      StRdData: begin
        w_side  = REQ_RD;
        w_beat  = rd_data_valid;
        r_valid = rd_data_valid;
        r_data  = rd_data;
      end
      default: w_state_nxt = StIdle;
    endcase

    // Shared data-phase bookkeeping; a completing beat wins over the watchdog.
    if (r_state == StWrData || r_state == StRdData) begin
      if (w_beat) begin
        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
      end
      if (w_beat && (r_beat_cnt == LastBeat)) begin
        w_done      = (w_side == REQ_WR);
        r_done      = (w_side == REQ_RD);
        w_arb_upd   = 1'b1;
        w_state_nxt = StIdle;
      end else if (r_wdog == WdogMax) begin
        err         = 1'b1;
        w_arb_upd   = 1'b1;
        w_state_nxt = StIdle;
      end else begin
        w_wdog_nxt = r_wdog + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_ddr3_arbiter.sv
// Directed bench for jpeg_ddr3_arbiter: write/read bursts, arbitration,
// backpressure, watchdog abort, calibration gating and asynchronous reset.
module tb_jpeg_ddr3_arbiter;

  localparam int unsigned AW    = 28;
  localparam int unsigned BEATS = 8;
  localparam int unsigned TMO   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_calib_complete;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [127:0]  w_data;
  logic          w_gnt, w_data_req, w_done;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_gnt;
  logic [127:0]  r_data;
  logic          r_valid, r_done, err;
  logic          cmd_ready;
  logic [2:0]    cmd;
  logic          cmd_en;
  logic [AW-1:0] addr;
  logic          wr_data_rdy;
  logic [127:0]  wr_data;
  logic          wr_data_en, wr_data_end;
  logic [15:0]   wr_data_mask;
  logic [127:0]  rd_data;
  logic          rd_data_valid, rd_data_end;

  int n_vec = 0;
  int n_err = 0;

  wire [312:0] all_outs = {w_gnt, w_data_req, w_done, r_gnt, r_valid, r_done, err, cmd_en,
                           wr_data_en, wr_data_end, cmd, addr, r_data, wr_data, wr_data_mask};

  always #5 clk = ~clk;

  jpeg_ddr3_arbiter #(
    .BURST_BEATS (BEATS),
    .TIMEOUT     (TMO),
    .ADDR_W      (AW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .w_req               (w_req),
    .w_addr              (w_addr),
    .w_data              (w_data),
    .w_gnt               (w_gnt),
    .w_data_req          (w_data_req),
    .w_done              (w_done),
    .r_req               (r_req),
    .r_addr              (r_addr),
    .r_gnt               (r_gnt),
    .r_data              (r_data),
    .r_valid             (r_valid),
    .r_done              (r_done),
    .err                 (err),
    .cmd_ready           (cmd_ready),
    .cmd                 (cmd),
    .cmd_en              (cmd_en),
    .addr                (addr),
    .wr_data_rdy         (wr_data_rdy),
    .wr_data             (wr_data),
    .wr_data_en          (wr_data_en),
    .wr_data_end         (wr_data_end),
    .wr_data_mask        (wr_data_mask),
    .rd_data             (rd_data),
    .rd_data_valid       (rd_data_valid),
    .rd_data_end         (rd_data_end)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    init_calib_complete = 1'b0;
    w_req = 1'b0; w_addr = '0; w_data = '0;
    r_req = 1'b0; r_addr = '0;
    cmd_ready = 1'b0; wr_data_rdy = 1'b0;
    rd_data = '0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    init_calib_complete = 1'b1; w_req = 1'b1; r_req = 1'b1; cmd_ready = 1'b1;
    wr_data_rdy = 1'b1; rd_data_valid = 1'b1; rd_data = '1; w_data = '1; w_addr = '1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    do_reset();
  endtask

  task automatic test_write_burst();
    int beats = 0, dones = 0, done_at = -1, extra_gnt = 0;
    do_reset();
    init_calib_complete = 1'b1; cmd_ready = 1'b1; wr_data_rdy = 1'b1;
    w_addr = 28'h0ABCDE0;
    @(negedge clk); w_req = 1'b1; #1;
    n_vec++;
    if (cmd_en !== 1'b0) begin n_err++; $display("FAIL wr_cmd_early: got %b want 0", cmd_en); end
    @(negedge clk); w_req = 1'b0; #1;
    n_vec++;
    if ({cmd_en, cmd, w_gnt} !== 5'b1_000_1) begin
      n_err++; $display("FAIL wr_cmd_phase: got en/cmd/gnt %b want 1_000_1", {cmd_en, cmd, w_gnt});
    end
    n_vec++;
    if (addr !== 28'h0ABCDE0) begin
      n_err++; $display("FAIL wr_cmd_addr: got %h want 0abcde0", addr);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); w_data = 128'h5A00_0000 + 128'(beats); #1;
      if (w_gnt) extra_gnt++;
      if (wr_data_en) begin
        n_vec++;
        if ({wr_data_end, w_data_req, wr_data, wr_data_mask} !== {2'b11, w_data, 16'h0}) begin
          n_err++;
          $display("FAIL wr_beat%0d: got end/req %b data %h mask %h want 11 %h 0", beats,
                   {wr_data_end, w_data_req}, wr_data, wr_data_mask, w_data);
        end
        beats++;
      end
      if (w_done) begin dones++; done_at = beats; end
    end
    n_vec++;
    if (beats != 8) begin n_err++; $display("FAIL wr_beat_count: got %0d want 8", beats); end
    n_vec++;
    if (dones != 1 || done_at != 8) begin
      n_err++; $display("FAIL wr_done: got %0d pulses at beat %0d want 1 at 8", dones, done_at);
    end
    n_vec++;
    if (extra_gnt != 0) begin n_err++; $display("FAIL wr_gnt_once: got %0d extra want 0", extra_gnt); end
  endtask

  task automatic test_simultaneous();
    string order = "";
    int ngr = 0, t0 = -1, t1 = -1;
    do_reset();
    init_calib_complete = 1'b1; cmd_ready = 1'b1; wr_data_rdy = 1'b1;
    rd_data_valid = 1'b1; rd_data = 128'h77;
    w_addr = 28'h0100000; r_addr = 28'h0200000;
    w_req = 1'b1; r_req = 1'b1;
    for (int c = 0; c < 100 && ngr < 4; c++) begin
      @(negedge clk); #1;
      if (w_gnt || r_gnt) begin
        order = {order, w_gnt ? "W" : "R"};
        n_vec++;
        if (addr !== (w_gnt ? 28'h0100000 : 28'h0200000)) begin
          n_err++; $display("FAIL sim_addr%0d: got %h want %s-side addr", ngr, addr, w_gnt ? "W" : "R");
        end
        if (ngr == 0) t0 = c;
        if (ngr == 1) t1 = c;
        ngr++;
      end
    end
    w_req = 1'b0; r_req = 1'b0;
    n_vec++;
    if (order != "WRWR") begin n_err++; $display("FAIL sim_order: got %s want WRWR", order); end
    n_vec++;
    if (t1 - t0 != 10) begin n_err++; $display("FAIL sim_gap: got %0d want 10", t1 - t0); end
    repeat (12) @(negedge clk);
    rd_data_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int held = 0, beats = 0, done_k = -1;
    do_reset();
    init_calib_complete = 1'b1; w_addr = 28'h0300000;
    @(negedge clk); w_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); w_req = 1'b0; #1;
      if (cmd_en && !w_gnt) held++;
    end
    n_vec++;
    if (held != 5) begin n_err++; $display("FAIL bp_cmd_hold: got %0d want 5", held); end
    @(negedge clk); cmd_ready = 1'b1; #1;
    n_vec++;
    if ({cmd_en, w_gnt} !== 2'b11) begin
      n_err++; $display("FAIL bp_gnt_cycle6: got %b want 11", {cmd_en, w_gnt});
    end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk); wr_data_rdy = ((k % 2) == 1); #1;
      if (wr_data_en) beats++;
      if (w_done) done_k = k;
    end
    wr_data_rdy = 1'b0;
    n_vec++;
    if (beats != 8) begin n_err++; $display("FAIL bp_beats: got %0d want 8", beats); end
    n_vec++;
    if (done_k != 15) begin n_err++; $display("FAIL bp_done_cycle: got %0d want 15", done_k); end
  endtask

  task automatic test_read_burst();
    int beats = 0, dones = 0, done_k = -1;
    logic exp_v;
    do_reset();
    init_calib_complete = 1'b1; cmd_ready = 1'b1; r_addr = 28'h0400040;
    @(negedge clk); rd_data_valid = 1'b1; rd_data = 128'hDEAD; r_req = 1'b1; #1;
    n_vec++;
    if ({r_valid, r_data} !== 129'h0) begin
      n_err++; $display("FAIL rd_stray_idle: got valid %b data %h want 0", r_valid, r_data);
    end
    @(negedge clk); r_req = 1'b0; #1;
    n_vec++;
    if ({cmd_en, cmd, r_gnt, r_valid} !== 6'b1_001_1_0) begin
      n_err++; $display("FAIL rd_cmd_phase: got en/cmd/gnt/valid %b want 1_001_1_0",
                        {cmd_en, cmd, r_gnt, r_valid});
    end
    n_vec++;
    if (addr !== 28'h0400040) begin n_err++; $display("FAIL rd_cmd_addr: got %h want 0400040", addr); end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk); rd_data_valid = ((k % 2) == 0); rd_data = 128'(beats); #1;
      exp_v = ((k % 2) == 0) && (k <= 14);
      n_vec++;
      if (r_valid !== exp_v) begin
        n_err++; $display("FAIL rd_valid_k%0d: got %b want %b", k, r_valid, exp_v);
      end
      if (r_valid) begin
        n_vec++;
        if (r_data !== 128'(beats)) begin
          n_err++; $display("FAIL rd_data%0d: got %h want %0h", beats, r_data, beats);
        end
        beats++;
      end
      if (r_done) begin dones++; done_k = k; end
    end
    rd_data_valid = 1'b0;
    n_vec++;
    if (dones != 1 || done_k != 14) begin
      n_err++; $display("FAIL rd_done: got %0d pulses at k=%0d want 1 at 14", dones, done_k);
    end
  endtask

  task automatic test_watchdog();
    int errs = 0, err_k = -1, rdones = 0, first = 0, gnt_k = -1;
    do_reset();
    init_calib_complete = 1'b1; cmd_ready = 1'b1; wr_data_rdy = 1'b1;
    @(negedge clk); w_req = 1'b1;
    @(negedge clk); w_req = 1'b0;
    repeat (9) @(negedge clk);
    r_req = 1'b1; r_addr = 28'h0500000;
    @(negedge clk); r_req = 1'b0; #1;
    n_vec++;
    if (r_gnt !== 1'b1) begin n_err++; $display("FAIL wd_rd_gnt: got %b want 1", r_gnt); end
    for (int k = 0; k < 30 && first == 0; k++) begin
      @(negedge clk); rd_data_valid = (k < 3); rd_data = 128'(k);
      if (k == 10) begin w_req = 1'b1; r_req = 1'b1; end
      #1;
      if (err) begin errs++; err_k = k; end
      if (r_done) rdones++;
      if (w_gnt || r_gnt) begin first = w_gnt ? 1 : 2; gnt_k = k; end
    end
    w_req = 1'b0; r_req = 1'b0; rd_data_valid = 1'b0;
    n_vec++;
    if (errs != 1 || err_k != 16) begin
      n_err++; $display("FAIL wd_err: got %0d pulses at k=%0d want 1 at 16", errs, err_k);
    end
    n_vec++;
    if (rdones != 0) begin n_err++; $display("FAIL wd_no_done: got %0d want 0", rdones); end
    n_vec++;
    if (first != 1 || gnt_k != 18) begin
      n_err++; $display("FAIL wd_next_gnt: got side %0d at k=%0d want 1(W) at 18", first, gnt_k);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_calib_reset();
    int en_seen = 0, beats = 0, dones = 0;
    do_reset();
    cmd_ready = 1'b1; wr_data_rdy = 1'b1;
    w_addr = 28'h0600000; r_addr = 28'h0700000;
    w_req = 1'b1; r_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (cmd_en) en_seen++;
    end
    n_vec++;
    if (en_seen != 0) begin n_err++; $display("FAIL calib_block: got %0d cmd_en want 0", en_seen); end
    @(negedge clk); init_calib_complete = 1'b1; r_req = 1'b0;
    @(negedge clk); init_calib_complete = 1'b0; #1;
    n_vec++;
    if (w_gnt !== 1'b1) begin n_err++; $display("FAIL calib_gnt: got %b want 1", w_gnt); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (wr_data_en) beats++;
      if (w_done) dones++;
    end
    n_vec++;
    if (beats != 8 || dones != 1) begin
      n_err++; $display("FAIL calib_drop_burst: got %0d beats %0d done want 8 1", beats, dones);
    end
    en_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (cmd_en) en_seen++;
    end
    n_vec++;
    if (en_seen != 0) begin n_err++; $display("FAIL calib_no_regrant: got %0d want 0", en_seen); end
    @(negedge clk); init_calib_complete = 1'b1;
    repeat (3) @(negedge clk);
    #1; rst_n = 1'b0; w_req = 1'b0; #1;
    n_vec++;
    if (all_outs !== '0) begin n_err++; $display("FAIL rst_mid_write: got %h want 0", all_outs); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if ({cmd_en, wr_data_en} !== 2'b00) begin
      n_err++; $display("FAIL rst_idle_after: got %b want 00", {cmd_en, wr_data_en});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_write_burst();
    test_simultaneous();
    test_backpressure();
    test_read_burst();
    test_watchdog();
    test_calib_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jpeg_ddr3_arbiter.md
# jpeg_ddr3_arbiter

Shares the single DDR3 user interface between the MJPEG frame writer and the UDP frame reader. It runs in the DDR3 user clock domain (`half_memory_clk`) and sits directly on the DDR3 IP `cmd` / `wr_data` / `rd_data` ports. It grants bursts round-robin, sequences each burst's command and data phases, and aborts a stalled burst on a watchdog.

## Interface
Parameters:
- `BURST_BEATS`, default 8: 128-bit beats per command; matches `app_burst_number` 7.
- `TIMEOUT`, default 1024: maximum cycles allowed in a data phase before abort.
- `ADDR_W`, default 28: DDR3 user address width.

Ports:
- `clk` in 1: DDR3 user clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `init_calib_complete` in 1: DDR3 ready.
- `w_req` in 1: writer requests one burst.
- `w_addr` in `ADDR_W`: writer burst address, stable while `w_req` is high.
- `w_data` in 128: writer beat, show-ahead.
- `w_gnt` out 1: one-cycle pulse when the write command is accepted.
- `w_data_req` out 1: beat consumed; writer advances.
- `w_done` out 1: one-cycle pulse after the last beat.
- `r_req` in 1: reader requests one burst.
- `r_addr` in `ADDR_W`: reader burst address.
- `r_gnt` out 1: one-cycle pulse when the read command is accepted.
- `r_data` out 128: read beat.
- `r_valid` out 1: `r_data` valid.
- `r_done` out 1: one-cycle pulse on the last read beat.
- `err` out 1: one-cycle pulse on watchdog abort.
- `cmd_ready` in 1, `cmd` out 3, `cmd_en` out 1, `addr` out `ADDR_W`: DDR3 command port.
- `wr_data_rdy` in 1, `wr_data` out 128, `wr_data_en` out 1, `wr_data_end` out 1, `wr_data_mask` out 16: DDR3 write port.
- `rd_data` in 128, `rd_data_valid` in 1, `rd_data_end` in 1: DDR3 read port.

## Operation
States and transitions:
- **IDLE**:
  - Accepts requests only if `init_calib_complete` is high.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the side not served last. The last-served flag resets to "read", so the write side wins first.
  - On grant, latch the address and go to WR_CMD or RD_CMD.
- **WR_CMD / RD_CMD**:
  - `cmd_en` is 1 and `addr` holds the latched value.
  - `cmd` is 3'b000 for write and 3'b001 for read.
  - The command is accepted on the cycle where `cmd_en & cmd_ready`.
  - On acceptance, pulse `w_gnt` or `r_gnt`, clear the beat counter and watchdog, and go to WR_DATA or RD_DATA.
- **WR_DATA**:
  - Combinational: `wr_data_en` = `wr_data_end` = `w_data_req` = `wr_data_rdy`.
  - `wr_data` = `w_data`; `wr_data_mask` = 0.
  - Count beats. On beat `BURST_BEATS`, pulse `w_done`, update last-served to "write", and return to IDLE.
- **RD_DATA**:
  - Combinational: `r_valid` = `rd_data_valid`; `r_data` = `rd_data`.
  - Count valid beats. On beat `BURST_BEATS`, pulse `r_done` on that same beat, update last-served to "read", and return to IDLE.
  - `rd_data_end` is ignored; the count is authoritative.

Arithmetic and width rules:
- The beat counter is `$clog2(BURST_BEATS+1)` bits.
- The watchdog is `$clog2(TIMEOUT+1)` bits, saturating.
- Address passes through unmodified; the requester owns address increment.

Boundary conditions:
- **Watchdog expiry**: the watchdog reaches `TIMEOUT` in a data phase without the burst completing.
  - Pulse `err` and go to IDLE.
  - Do not pulse `w_done` or `r_done`.
  - Last-served is still updated, so the other side gets the next grant.
- **`init_calib_complete` falls mid-burst**: the burst completes normally; no new grant is issued.
- **Request withdrawn**: `w_req` or `r_req` falling after the grant has no effect.
- **Read data outside RD_DATA**: `rd_data_valid` in any other state is dropped and `r_valid` stays 0.
- **Reset mid-burst**: return to IDLE immediately; the outstanding DDR3 burst is abandoned.

## Timing
- Reset values:
  - All outputs are 0, including `cmd`, `addr` and `wr_data_mask`.
  - State is IDLE and last-served is "read".
- Grant latency:
  - The request is sampled in IDLE.
  - `cmd_en` is high on the next cycle.
  - The grant pulse coincides with the `cmd_ready` handshake cycle.
- The data phase starts the cycle after the handshake.
- Write throughput is one beat per `wr_data_rdy` cycle; a burst takes at least `BURST_BEATS` cycles.
- Back-to-back bursts:
  - IDLE costs one cycle, so the minimum burst-to-burst gap is 2 cycles (IDLE plus CMD).
  - Round-robin guarantees alternation when both requesters stay high.
- The `*_done` to IDLE transition is the cycle after the last beat.

## Structure
- Shared package `ddr3_arb_pkg`:
  - State enum.
  - Constants `DDR3_CMD_WR` = 3'b000 and `DDR3_CMD_RD` = 3'b001.
  - Requester-select enum {REQ_WR, REQ_RD}.
- Sub-module `rr_arb2`: two-requester round-robin with a last-served register and update strobe, reusable for future requesters.
- Everything else lives in a single module.

## Test plan
- **Write burst**: calibration complete, `w_req` high, `cmd_ready` high.
  - `cmd_en` is high 1 cycle after the request and `cmd` = 0.
  - `w_gnt` pulses once.
  - With `wr_data_rdy` always high, exactly 8 `wr_data_en` beats follow, then a `w_done` pulse.
- **Simultaneous requests**: `w_req` and `r_req` held high for 4 bursts.
  - Grant order is W, R, W, R.
  - `addr` matches each side's latched address.
- **Backpressure**:
  - `cmd_ready` low for 5 cycles: `cmd_en` is held for 5 cycles and the grant occurs on cycle 6.
  - `wr_data_rdy` toggling 1/0: 8 beats complete over 16 cycles.
- **Read burst**: `rd_data_valid` given 8 beats with gaps, `rd_data` = beat index.
  - `r_data` passes through 0..7.
  - `r_done` pulses on beat 8.
  - A stray valid seen in IDLE is not forwarded.
- **Watchdog**: `TIMEOUT` = 16, read issued with only 3 valid beats returned.
  - `err` pulses 16 cycles after the data phase starts.
  - No `r_done` pulse.
  - The next grant goes to the write side.
- **Calibration and reset**:
  - `init_calib_complete` low with requests pending: no `cmd_en`.
  - `rst_n` low mid-write: all outputs are 0 in the same cycle and state is IDLE.
